// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access controller.
// Optional load bypass is enabled by DMEM_LOAD_BYPASS_EN.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int TIMEOUT_DEFAULT = 256;
  localparam int ADDR_W_DEFAULT  = 32;
  localparam int WADDR_W         = ADDR_W_DEFAULT - 2;

  localparam logic [31:0] DEAD_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Clear/enable watchdog counter that saturates at TIMEOUT-1.
// expired_o is high while the count sits at its final value.
module dmem_timeout_cnt
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Multi-cycle D-port controller: stalls the core around one memory access.
// `define DMEM_LOAD_BYPASS_EN adds a one-entry last-load bypass tag.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_wen,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  output logic              core_err,
  output logic              core_misalign,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_e            state_q;
  logic [ADDR_W-3:0] addr_q;
  logic              wen_q;
  logic              mis_q;
  logic              err_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              expired;
  logic              hit;
  logic              accept;
  logic              in_idle;

  assign in_idle = (state_q == IDLE);
  assign accept  = in_idle && core_req && !hit;

`ifdef DMEM_LOAD_BYPASS_EN
  logic [ADDR_W-3:0] tag_q;
  logic              tag_v_q;
  logic              tag_match;

  assign tag_match = (tag_q == core_addr[ADDR_W-1:2]);
  assign hit = in_idle && core_req && !core_wen
            && tag_v_q && tag_match;

  // rdata_q only changes on load completion, which also refreshes the tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '0;
      tag_v_q <= 1'b0;
    end else if (state_q == WAIT) begin
      if (mem_ready && !wen_q) begin
        tag_q   <= addr_q;
        tag_v_q <= 1'b1;
      end else if (!mem_ready && expired) begin
        tag_v_q <= 1'b0;
      end
    end else if (accept && core_wen && tag_match) begin
      tag_v_q <= 1'b0;
    end
  end
`else
  assign hit = 1'b0;
`endif

  dmem_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_q == REQ),
    .en_i      (state_q == WAIT),
    .expired_o (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q  <= core_addr[ADDR_W-1:2];
            wen_q   <= core_wen;
            wdata_q <= core_wdata;
            mis_q   <= |core_addr[1:0];
            state_q <= REQ;
          end
        end
        REQ: state_q <= WAIT;
        WAIT: begin
          if (mem_ready) begin
            if (!wen_q) rdata_q <= mem_rdata;
            state_q <= DONE;
          end else if (expired) begin
            err_q <= 1'b1;
            if (!wen_q) rdata_q <= DATA_W'(DEAD_DATA);
            state_q <= DONE;
          end
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end

  // IDLE stall is combinational: the core must freeze in the request cycle
  assign core_stall = in_idle ? (core_req && !hit)
                              : (state_q != DONE);

  assign core_rdata    = rdata_q;
  assign core_err      = err_q;
  assign core_misalign = (state_q == DONE) && mis_q;
  assign mem_cen       = (state_q == REQ);
  assign mem_wen       = wen_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a cycle-level expectation queue.
// Bypass vectors run only when DMEM_LOAD_BYPASS_EN is defined.
module tb_dmem_access_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_wen;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_stall, core_err, core_misalign;
  logic        mem_cen, mem_wen;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ready;

  always #5 clk = ~clk;

  dmem_access_ctrl #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO),
    .CNT_W  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .core_req     (core_req),
    .core_wen     (core_wen),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .core_rdata   (core_rdata),
    .core_stall   (core_stall),
    .core_err     (core_err),
    .core_misalign(core_misalign),
    .mem_cen      (mem_cen),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready)
  );

  typedef struct {
    logic        stall, cen, wen, mis, err;
    logic [29:0] wa;
    logic [31:0] wd, rd;
  } exp_t;

  exp_t q[$];
  exp_t e;

  int nvec = 0, nerr = 0;
  int stall_cnt = 0, cen_cnt = 0, mis_cnt = 0;

  // model of architecturally visible state
  logic [31:0] m_rdata = '0;
  logic        m_err   = 1'b0;
  logic [29:0] m_tag   = '0;
  logic        m_tv    = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (core_stall) stall_cnt++;
    if (mem_cen) cen_cnt++;
    if (core_misalign) mis_cnt++;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("core_stall", {31'd0, core_stall}, {31'd0, e.stall});
      chk("mem_cen", {31'd0, mem_cen}, {31'd0, e.cen});
      chk("core_misalign", {31'd0, core_misalign}, {31'd0, e.mis});
      chk("core_err", {31'd0, core_err}, {31'd0, e.err});
      chk("core_rdata", core_rdata, e.rd);
      if (e.cen) begin
        chk("mem_wen", {31'd0, mem_wen}, {31'd0, e.wen});
        chk("mem_addr", {2'd0, mem_addr}, {2'd0, e.wa});
        chk("mem_wdata", mem_wdata, e.wd);
      end
    end
  end

  task automatic push(input logic st, input logic cen, input logic mis,
                      input logic [29:0] wa, input logic w,
                      input logic [31:0] wd);
    exp_t x;
    x.stall = st; x.cen = cen; x.mis = mis; x.err = m_err;
    x.wa = wa; x.wen = w; x.wd = wd; x.rd = m_rdata;
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      core_req = 1'b0; mem_ready = 1'b0;
      push(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    end
  endtask

  // One core instruction; dly = WAIT index of mem_ready, <0 = never
  task automatic access(input logic [31:0] addr, input logic wen,
                        input logic [31:0] wd, input int dly,
                        input logic [31:0] rd, input logic spur);
    logic [29:0] wa;
    logic mis, hit, to;
    int n;
    wa  = addr[31:2];
    mis = |addr[1:0];
    hit = 1'b0;
`ifdef DMEM_LOAD_BYPASS_EN
    hit = !wen && m_tv && (m_tag == wa);
`endif
    stall_cnt = 0; cen_cnt = 0; mis_cnt = 0;
    @(posedge clk); #1;
    core_req = 1'b1; core_wen = wen; core_addr = addr;
    core_wdata = wd; mem_ready = spur; mem_rdata = 32'hBAD00000;
    if (hit) begin
      push(1'b0, 1'b0, 1'b0, wa, wen, wd);
    end else begin
      push(1'b1, 1'b0, 1'b0, wa, wen, wd);
      @(posedge clk); #1;
      mem_ready = spur;
      push(1'b1, 1'b1, 1'b0, wa, wen, wd);
      to = (dly < 0) || (dly >= TO);
      n  = to ? TO : dly + 1;
      for (int k = 0; k < n; k++) begin
        @(posedge clk); #1;
        mem_ready = (k == dly);
        mem_rdata = rd;
        push(1'b1, 1'b0, 1'b0, wa, wen, wd);
      end
      if (to) begin
        m_err = 1'b1;
        m_tv  = 1'b0;
        if (!wen) m_rdata = 32'hDEADBEEF;
      end else if (!wen) begin
        m_rdata = rd;
        m_tag   = wa;
        m_tv    = 1'b1;
      end
      if (wen && (wa == m_tag)) m_tv = 1'b0;
      @(posedge clk); #1;
      mem_ready = spur;
      mem_rdata = ~rd;
      push(1'b0, 1'b0, mis, wa, wen, wd);
    end
    @(negedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    core_req = 1'b0; core_wen = 1'b0;
    core_addr = '0; core_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'd0, core_stall}, 32'd0);
    chk("rst_cen", {31'd0, mem_cen}, 32'd0);
    chk("rst_rdata", core_rdata, 32'd0);
    chk("rst_maddr", {2'd0, mem_addr}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // load, ready in first WAIT
    access(32'h10, 1'b0, 32'h0, 0, 32'h12345678, 1'b0);
    chk("t1_rdata", core_rdata, 32'h12345678);
    chk("t1_stall_cycles", stall_cnt, 32'd3);
    chk("t1_cen_cycles", cen_cnt, 32'd1);
    idle(1);

    // store, five WAIT cycles, spurious ready outside WAIT
    access(32'h20, 1'b1, 32'hA5A5A5A5, 4, 32'hFFFF0000, 1'b1);
    chk("t2_stall_cycles", stall_cnt, 32'd7);
    chk("t2_rdata_kept", core_rdata, 32'h12345678);
    chk("t2_cen_cycles", cen_cnt, 32'd1);

    // back-to-back load that times out
    access(32'h30, 1'b0, 32'h0, -1, 32'h0, 1'b0);
    chk("t3_rdata", core_rdata, 32'hDEADBEEF);
    chk("t3_err", {31'd0, core_err}, 32'd1);
    chk("t3_stall_cycles", stall_cnt, 32'd10);
    idle(3);
    chk("t3_err_sticky", {31'd0, core_err}, 32'd1);

    // back-to-back loads
    access(32'h08, 1'b0, 32'h0, 2, 32'hCAFEF00D, 1'b1);
    access(32'h0C, 1'b0, 32'h0, 0, 32'h0BADC0DE, 1'b0);
    chk("t4_rdata", core_rdata, 32'h0BADC0DE);
    chk("t4_cen_cycles", cen_cnt, 32'd1);
    idle(1);

    // reset pulse in the middle of WAIT
    @(posedge clk); #1;
    core_req = 1'b1; core_wen = 1'b0; core_addr = 32'h50;
    push(1'b1, 1'b0, 1'b0, 30'h14, 1'b0, 32'h0);
    @(posedge clk); #1;
    push(1'b1, 1'b1, 1'b0, 30'h14, 1'b0, 32'h0);
    repeat (2) begin
      @(posedge clk); #1;
      push(1'b1, 1'b0, 1'b0, 30'h14, 1'b0, 32'h0);
    end
    @(posedge clk); #1;
    core_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", {31'd0, core_stall}, 32'd0);
    chk("mid_rst_err", {31'd0, core_err}, 32'd0);
    chk("mid_rst_rdata", core_rdata, 32'd0);
    chk("mid_rst_maddr", {2'd0, mem_addr}, 32'd0);
    m_rdata = '0; m_err = 1'b0; m_tv = 1'b0; m_tag = '0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b1; mem_rdata = 32'h77777777;
    push(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    idle(1);

    // misaligned load
    access(32'h13, 1'b0, 32'h0, 1, 32'h55AA55AA, 1'b0);
    chk("t6_mis_pulses", mis_cnt, 32'd1);
    chk("t6_maddr", {2'd0, mem_addr}, 32'h4);
    chk("t6_rdata", core_rdata, 32'h55AA55AA);
    idle(2);

`ifdef DMEM_LOAD_BYPASS_EN
    access(32'h40, 1'b0, 32'h0, 0, 32'h11112222, 1'b0);
    access(32'h40, 1'b0, 32'h0, 0, 32'h0, 1'b0);
    chk("byp_hit_stall", stall_cnt, 32'd0);
    chk("byp_hit_cen", cen_cnt, 32'd0);
    chk("byp_hit_rdata", core_rdata, 32'h11112222);
    idle(1);
    access(32'h40, 1'b1, 32'h99990000, 0, 32'h0, 1'b0);
    access(32'h40, 1'b0, 32'h0, 0, 32'h33334444, 1'b0);
    chk("byp_miss_stall", stall_cnt, 32'd3);
    chk("byp_miss_cen", cen_cnt, 32'd1);
    chk("byp_miss_rdata", core_rdata, 32'h33334444);
    idle(2);
`endif

    idle(1);
    @(negedge clk); #1;
    chk("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
